// File: rtl/bp_resolve_if.sv
// Fetch/execute-facing signal bundle for the branch resolve queue.
// The master side drives branch pushes and resolutions; the slave side is the queue.
interface bp_resolve_if #(
  parameter int IDX_W = 5,
  parameter int CNT_W = 3
);
  logic             push;
  logic [31:0]      push_pc;
  logic             push_pred;
  logic [31:0]      push_target;
  logic             res_valid;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             flush;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             upd_we;
  logic [IDX_W-1:0] upd_waddr;
  logic             upd_taken;
  logic             mispredict;
  logic [31:0]      redirect_pc;
  logic             err;

  modport master (
    output push, push_pc, push_pred, push_target,
    output res_valid, res_taken, res_target, flush,
    input  full, empty, count, upd_we, upd_waddr, upd_taken,
    input  mispredict, redirect_pc, err
  );

  modport slave (
    input  push, push_pc, push_pred, push_target,
    input  res_valid, res_taken, res_target, flush,
    output full, empty, count, upd_we, upd_waddr, upd_taken,
    output mispredict, redirect_pc, err
  );
endinterface

// File: rtl/bp_resolve_queue.sv
// In-order queue of predicted conditional branches; pairs the oldest entry with its
// execute outcome, drives the bimodal table update and the mispredict redirect.
module bp_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  bp_resolve_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      pc_mem_q   [DEPTH];
  logic             pred_mem_q [DEPTH];
  logic [31:0]      tgt_mem_q  [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             upd_we_q, upd_we_d;
  logic [IDX_W-1:0] upd_waddr_q, upd_waddr_d;
  logic             upd_taken_q, upd_taken_d;
  logic             mispredict_q, mispredict_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             err_q, err_d;

  logic             full;
  logic             empty;
  logic             pop;
  logic             mis;
  logic             clear;
  logic             push_acc;
  logic [31:0]      head_pc;
  logic             head_pred;
  logic [31:0]      head_tgt;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_pc   = pc_mem_q[head_q];
  assign head_pred = pred_mem_q[head_q];
  assign head_tgt  = tgt_mem_q[head_q];

  always_comb begin
    pop      = bus.res_valid && !empty;
    mis      = pop && ((bus.res_taken != head_pred) ||
                       (bus.res_taken && head_pred && (bus.res_target != head_tgt)));
    clear    = mis || bus.flush;
    push_acc = bus.push && !clear && (!full || pop);

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)      head_d = head_q + PTR_W'(1);
      if (push_acc) tail_d = tail_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_acc) - CNT_W'(pop);
    end

    // Registered outputs carry information only for the cycle after a pop.
    upd_we_d      = pop;
    upd_waddr_d   = pop ? head_pc[IDX_W+1:2] : '0;
    upd_taken_d   = pop && bus.res_taken;
    mispredict_d  = mis;
    redirect_pc_d = '0;
    if (mis) redirect_pc_d = bus.res_taken ? bus.res_target : head_pc + 32'd4;

    err_d = err_q
          || (bus.res_valid && empty)
          || (bus.push && full && !pop && !clear);
  end

  // Entry storage carries no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      pc_mem_q[tail_q]   <= bus.push_pc;
      pred_mem_q[tail_q] <= bus.push_pred;
      tgt_mem_q[tail_q]  <= bus.push_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      upd_we_q      <= 1'b0;
      upd_waddr_q   <= '0;
      upd_taken_q   <= 1'b0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
      err_q         <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      upd_we_q      <= upd_we_d;
      upd_waddr_q   <= upd_waddr_d;
      upd_taken_q   <= upd_taken_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
      err_q         <= err_d;
    end
  end

  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.count       = count_q;
  assign bus.upd_we      = upd_we_q;
  assign bus.upd_waddr   = upd_waddr_q;
  assign bus.upd_taken   = upd_taken_q;
  assign bus.mispredict  = mispredict_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed vector bench for bp_resolve_queue (DEPTH=4, IDX_W=5).
module tb_bp_resolve_queue;

  localparam int DEPTH = 4;
  localparam int IDX_W = 5;

  typedef struct {
    logic        push;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] tgt;
    logic        rv;
    logic        rt;
    logic [31:0] rtgt;
    logic        flush;
    logic [31:0] e_count;
    logic        e_we;
    logic [31:0] e_waddr;
    logic        e_taken;
    logic        e_mis;
    logic [31:0] e_rpc;
    logic        e_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  vec_t tbl[$];

  bp_resolve_if #(.IDX_W(IDX_W), .CNT_W(3)) bus ();

  bp_resolve_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic push, logic [31:0] pc, logic pred, logic [31:0] tgt,
                              logic rv, logic rt, logic [31:0] rtgt, logic flush,
                              int c, logic we, int wa, logic tk, logic mis,
                              logic [31:0] rpc, logic err);
    vec_t v;
    v.push = push; v.pc = pc; v.pred = pred; v.tgt = tgt;
    v.rv = rv; v.rt = rt; v.rtgt = rtgt; v.flush = flush;
    v.e_count = c; v.e_we = we; v.e_waddr = wa; v.e_taken = tk;
    v.e_mis = mis; v.e_rpc = rpc; v.e_err = err;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.push = 1'b0; bus.push_pc = '0; bus.push_pred = 1'b0; bus.push_target = '0;
    bus.res_valid = 1'b0; bus.res_taken = 1'b0; bus.res_target = '0; bus.flush = 1'b0;
  endtask

  task automatic check_state(string tag, int c, logic we, int wa, logic tk,
                             logic mis, logic [31:0] rpc, logic err);
    check({tag, ".count"}, 32'(bus.count), c);
    check({tag, ".empty"}, 32'(bus.empty), 32'(c == 0));
    check({tag, ".full"}, 32'(bus.full), 32'(c == DEPTH));
    check({tag, ".upd_we"}, 32'(bus.upd_we), 32'(we));
    if (we) begin
      check({tag, ".upd_waddr"}, 32'(bus.upd_waddr), wa);
      check({tag, ".upd_taken"}, 32'(bus.upd_taken), 32'(tk));
    end
    check({tag, ".mispredict"}, 32'(bus.mispredict), 32'(mis));
    if (mis) check({tag, ".redirect_pc"}, bus.redirect_pc, rpc);
    check({tag, ".err"}, 32'(bus.err), 32'(err));
  endtask

  task automatic apply(string tag, vec_t v);
    bus.push = v.push; bus.push_pc = v.pc; bus.push_pred = v.pred; bus.push_target = v.tgt;
    bus.res_valid = v.rv; bus.res_taken = v.rt; bus.res_target = v.rtgt; bus.flush = v.flush;
    @(posedge clk);
    #1;
    idle_inputs();
    check_state(tag, int'(v.e_count), v.e_we, int'(v.e_waddr), v.e_taken, v.e_mis, v.e_rpc, v.e_err);
  endtask

  initial begin
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_state("reset", 0, 1'b0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("reset.redirect_pc", bus.redirect_pc, 32'h0);
    check("reset.upd_waddr", 32'(bus.upd_waddr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    //        push pc         pred tgt        rv rt rtgt       fl  cnt we wa tk mis rpc        err
    tbl.push_back(mk(1, 32'h100, 1, 32'h200, 0, 0, 32'h0,   0,  1, 0, 0, 0, 0, 32'h0,   0));
    tbl.push_back(mk(0, 32'h0,   0, 32'h0,   1, 1, 32'h200, 0,  0, 1, 0, 1, 0, 32'h0,   0));
    tbl.push_back(mk(1, 32'h104, 0, 32'h0,   0, 0, 32'h0,   0,  1, 0, 0, 0, 0, 32'h0,   0));
    tbl.push_back(mk(0, 32'h0,   0, 32'h0,   1, 1, 32'h80,  0,  0, 1, 1, 1, 1, 32'h80,  0));
    tbl.push_back(mk(0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0,  0, 0, 0, 0, 0, 32'h0,   0));
    tbl.push_back(mk(1, 32'h108, 1, 32'h300, 0, 0, 32'h0,   0,  1, 0, 0, 0, 0, 32'h0,   0));
    tbl.push_back(mk(1, 32'h10C, 0, 32'h0,   0, 0, 32'h0,   0,  2, 0, 0, 0, 0, 32'h0,   0));
    tbl.push_back(mk(1, 32'h110, 0, 32'h0,   0, 0, 32'h0,   0,  3, 0, 0, 0, 0, 32'h0,   0));
    tbl.push_back(mk(1, 32'h114, 0, 32'h0,   1, 0, 32'h0,   0,  0, 1, 2, 0, 1, 32'h10C, 0));
    tbl.push_back(mk(1, 32'h140, 1, 32'h500, 0, 0, 32'h0,   0,  1, 0, 0, 0, 0, 32'h0,   0));
    tbl.push_back(mk(0, 32'h0,   0, 32'h0,   1, 1, 32'h504, 0,  0, 1, 16,1, 1, 32'h504, 0));
    tbl.push_back(mk(1, 32'h120, 0, 32'h0,   0, 0, 32'h0,   0,  1, 0, 0, 0, 0, 32'h0,   0));
    tbl.push_back(mk(1, 32'h124, 0, 32'h0,   0, 0, 32'h0,   0,  2, 0, 0, 0, 0, 32'h0,   0));
    tbl.push_back(mk(1, 32'h128, 0, 32'h0,   0, 0, 32'h0,   0,  3, 0, 0, 0, 0, 32'h0,   0));
    tbl.push_back(mk(1, 32'h12C, 0, 32'h0,   0, 0, 32'h0,   0,  4, 0, 0, 0, 0, 32'h0,   0));
    tbl.push_back(mk(1, 32'h130, 0, 32'h0,   1, 0, 32'h0,   0,  4, 1, 8, 0, 0, 32'h0,   0));
    tbl.push_back(mk(1, 32'h134, 0, 32'h0,   0, 0, 32'h0,   0,  4, 0, 0, 0, 0, 32'h0,   1));
    tbl.push_back(mk(0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0,  3, 1, 9, 0, 0, 32'h0,   1));
    tbl.push_back(mk(0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0,  2, 1, 10,0, 0, 32'h0,   1));
    tbl.push_back(mk(0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0,  1, 1, 11,0, 0, 32'h0,   1));
    tbl.push_back(mk(0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0,  0, 1, 12,0, 0, 32'h0,   1));

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // Keep one branch in flight while cycling ten times so both pointers wrap.
    apply("wrap.init", mk(1, 32'h200, 1, 32'h400, 0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 32'h0, 1));
    for (int i = 0; i < 10; i++) begin
      apply($sformatf("wrap%0d", i),
            mk(i < 9, 32'h200 + 32'(4 * (i + 1)), 1, 32'h400 + 32'(i + 1),
               1, 1, 32'h400 + 32'(i), 0,
               (i < 9) ? 1 : 0, 1, i, 1, 0, 32'h0, 1));
    end

    // Mid-operation reset discards pending entries and the pending update.
    apply("prereset", mk(1, 32'h600, 0, 32'h0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 32'h0, 1));
    bus.res_valid = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check_state("midreset", 0, 1'b0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    apply("empty_res", mk(0, 32'h0,   0, 32'h0, 1, 1, 32'h40, 0, 0, 0, 0, 0, 0, 32'h0, 1));
    apply("fl.p0",     mk(1, 32'h700, 0, 32'h0, 0, 0, 32'h0,  0, 1, 0, 0, 0, 0, 32'h0, 1));
    apply("fl.p1",     mk(1, 32'h704, 0, 32'h0, 0, 0, 32'h0,  0, 2, 0, 0, 0, 0, 32'h0, 1));
    apply("fl.p2",     mk(1, 32'h708, 0, 32'h0, 0, 0, 32'h0,  0, 3, 0, 0, 0, 0, 32'h0, 1));
    apply("flush",     mk(1, 32'h70C, 0, 32'h0, 0, 0, 32'h0,  1, 0, 0, 0, 0, 0, 32'h0, 1));
    apply("postflush", mk(1, 32'h740, 1, 32'h9A0, 0, 0, 32'h0, 0, 1, 0, 0, 0, 0, 32'h0, 1));
    apply("postpop",   mk(0, 32'h0,   0, 32'h0, 1, 1, 32'h9A0, 0, 0, 1, 16, 1, 0, 32'h0, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
